// File: rtl/floating_divider.sv
// -----------------------------------------------------------------------------
// floating_divider
//
// Sequential IEEE-754 single-precision divider (a / b). A bit-serial restoring
// divider produces one quotient bit per clock. Denormal operands are flushed
// to zero, rounding is truncation, and out-of-range exponents saturate to
// infinity or flush to zero.
//
// Ports:
//   clk          system clock, rising-edge active
//   rst          asynchronous active-high reset
//   start        request pulse, sampled only while idle
//   a, b         dividend / divisor, {sign, exp[7:0], frac[22:0]}
//   busy         high from the accepting edge until the edge entering DONE
//   done         one-cycle completion pulse
//   result       packed quotient, held until overwritten by a later divide
//   div_by_zero  finite nonzero a divided by zero
//   invalid      0/0, inf/inf or a NaN operand
//   overflow     result saturated to infinity
//   underflow    result flushed to zero
// -----------------------------------------------------------------------------
module floating_divider #(
    parameter int QBITS = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        div_by_zero,
    output logic        invalid,
    output logic        overflow,
    output logic        underflow
);

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        DIVIDE,
        NORM,
        DONE
    } state_t;

    localparam logic [31:0] QNAN      = 32'h7FC0_0000;
    localparam logic [4:0]  LAST_STEP = 5'(QBITS - 1);

    state_t             state;
    logic [31:0]        op_a;
    logic [31:0]        op_b;
    logic               sign;
    logic signed [9:0]  exp_tmp;
    logic [23:0]        mb;
    logic [24:0]        rem;
    logic [QBITS-1:0]   q;
    logic [4:0]         count;

    // Operand classification, decoded from the latched operands.
    logic [7:0] ea, eb;
    logic       a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, q_sign;

    assign ea     = op_a[30:23];
    assign eb     = op_b[30:23];
    assign a_zero = (ea == 8'd0);
    assign b_zero = (eb == 8'd0);
    assign a_inf  = (ea == 8'hFF) && (op_a[22:0] == 23'd0);
    assign b_inf  = (eb == 8'hFF) && (op_b[22:0] == 23'd0);
    assign a_nan  = (ea == 8'hFF) && (op_a[22:0] != 23'd0);
    assign b_nan  = (eb == 8'hFF) && (op_b[22:0] != 23'd0);
    assign q_sign = op_a[31] ^ op_b[31];

    // One restoring step. After a subtraction rem < mb < 2^24, so dropping
    // bit 24 before the shift loses nothing.
    logic        rem_ge;
    logic [24:0] rem_sub;
    logic [24:0] rem_next;

    assign rem_ge   = (rem >= {1'b0, mb});
    assign rem_sub  = rem_ge ? (rem - {1'b0, mb}) : rem;
    assign rem_next = {rem_sub[23:0], 1'b0};

    // Normalisation: the quotient of two [1,2) mantissas lies in (0.5, 2),
    // so at most one position of left shift is needed.
    logic [23:0]       mant;
    logic signed [9:0] exp_norm;

    // NOTE: every signal assigned in always_comb gets a value on every path
    // (here via the if/else pair), otherwise synthesis infers a latch.
    always_comb begin
        if (q[QBITS-1]) begin
            mant     = q[QBITS-1:1];
            exp_norm = exp_tmp;
        end else begin
            mant     = q[QBITS-2:0];
            exp_norm = exp_tmp - 10'sd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= 32'd0;
            div_by_zero <= 1'b0;
            invalid     <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            op_a        <= 32'd0;
            op_b        <= 32'd0;
            sign        <= 1'b0;
            exp_tmp     <= 10'sd0;
            mb          <= 24'd0;
            rem         <= 25'd0;
            q           <= '0;
            count       <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_a        <= a;
                        op_b        <= b;
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
                        invalid     <= 1'b0;
                        overflow    <= 1'b0;
                        underflow   <= 1'b0;
                        state       <= UNPACK;
                    end
                end

                UNPACK: begin
                    sign <= q_sign;
                    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
                        result  <= QNAN;
                        invalid <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end else if (a_inf) begin
                        result <= {q_sign, 8'hFF, 23'd0};
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else if (b_inf) begin
                        result <= {q_sign, 31'd0};
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else if (b_zero) begin
                        result      <= {q_sign, 8'hFF, 23'd0};
                        div_by_zero <= 1'b1;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state       <= DONE;
                    end else if (a_zero) begin
                        result <= {q_sign, 31'd0};
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        exp_tmp <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
                        rem     <= {2'b01, op_a[22:0]};
                        mb      <= {1'b1, op_b[22:0]};
                        q       <= '0;
                        count   <= 5'd0;
                        state   <= DIVIDE;
                    end
                end

                DIVIDE: begin
                    // Quotient bits shift in at the LSB, so the first bit
                    // generated ends up in q[QBITS-1].
                    rem   <= rem_next;
                    q     <= {q[QBITS-2:0], rem_ge};
                    count <= count + 5'd1;
                    if (count == LAST_STEP) begin
                        state <= NORM;
                    end
                end

                NORM: begin
                    if (exp_norm >= 10'sd255) begin
                        result   <= {sign, 8'hFF, 23'd0};
                        overflow <= 1'b1;
                    end else if (exp_norm <= 10'sd0) begin
                        result    <= {sign, 31'd0};
                        underflow <= 1'b1;
                    end else begin
                        result <= {sign, exp_norm[7:0], mant[22:0]};
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end

                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_floating_divider.sv
// -----------------------------------------------------------------------------
// tb_floating_divider
//
// Self-checking bench for floating_divider. Expected results come from a
// behavioural model using integer division of the mantissas; directed vectors
// and randomised operands are both compared against it, along with latency,
// handshake and reset behaviour.
// -----------------------------------------------------------------------------
module tb_floating_divider;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        div_by_zero;
    logic        invalid;
    logic        overflow;
    logic        underflow;

    int n_checks = 0;
    int n_fail   = 0;

    floating_divider #(.QBITS(25)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .div_by_zero (div_by_zero),
        .invalid     (invalid),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // flags packed as {div_by_zero, invalid, overflow, underflow}
    typedef struct packed {
        logic        special;
        logic [3:0]  flags;
        logic [31:0] res;
    } expect_t;

    typedef struct packed {
        int          lat;
        logic [31:0] res;
        logic [3:0]  flags;
        logic        busy_err;
        logic        done_after;
        logic        busy_after;
        logic        rst_busy;
        logic        rst_done;
        logic [31:0] rst_res;
    } obs_t;

    // Reference model: a/b from the IEEE rules with flush-to-zero and
    // truncation, using plain integer division on the significands.
    function automatic expect_t model(input logic [31:0] x, input logic [31:0] y);
        expect_t r;
        int      ex, ey, e;
        longint  mx, my, qt, mant;
        logic    s, xz, yz, xi, yi, xn, yn;
        logic [7:0]  e8;
        logic [23:0] m24;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        s  = x[31] ^ y[31];
        xz = (ex == 0);
        yz = (ey == 0);
        xi = (ex == 255) && (x[22:0] == 0);
        yi = (ey == 255) && (y[22:0] == 0);
        xn = (ex == 255) && (x[22:0] != 0);
        yn = (ey == 255) && (y[22:0] != 0);
        r  = '0;
        r.special = 1'b1;
        if (xn || yn || (xz && yz) || (xi && yi)) begin
            r.flags = 4'b0100;
            r.res   = 32'h7FC0_0000;
        end else if (xi) begin
            r.res = {s, 8'hFF, 23'd0};
        end else if (yi) begin
            r.res = {s, 31'd0};
        end else if (yz) begin
            r.flags = 4'b1000;
            r.res   = {s, 8'hFF, 23'd0};
        end else if (xz) begin
            r.res = {s, 31'd0};
        end else begin
            r.special = 1'b0;
            mx = longint'({1'b1, x[22:0]});
            my = longint'({1'b1, y[22:0]});
            qt = (mx << 24) / my;
            e  = ex - ey + 127;
            if (qt >= (longint'(1) << 24)) begin
                mant = qt >> 1;
            end else begin
                mant = qt;
                e    = e - 1;
            end
            if (e >= 255) begin
                r.flags = 4'b0010;
                r.res   = {s, 8'hFF, 23'd0};
            end else if (e <= 0) begin
                r.flags = 4'b0001;
                r.res   = {s, 31'd0};
            end else begin
                e8    = 8'(e);
                m24   = 24'(mant);
                r.res = {s, e8, m24[22:0]};
            end
        end
        return r;
    endfunction

    // Drives one divide starting at the current negedge. inject_at issues a
    // competing start at that cycle, rst_at pulses reset at that cycle, and
    // poke_done raises start during the DONE cycle. Returns at a negedge in
    // the first IDLE cycle after DONE (or just after reset release).
    task automatic run_op(input logic [31:0] ai, input logic [31:0] bi,
                          input int inject_at, input int rst_at,
                          input logic poke_done, output obs_t o);
        o     = '0;
        a     = ai;
        b     = bi;
        start = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == inject_at) begin
                start = 1'b1;
                a     = ~ai ^ 32'h0055_1234;
                b     = 32'h3F80_0000;
            end
            if (i == rst_at) begin
                rst = 1'b1;
                #1;
                o.rst_busy = busy;
                o.rst_done = done;
                o.rst_res  = result;
                o.lat      = -1;
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            if (done) begin
                o.lat   = i;
                o.res   = result;
                o.flags = {div_by_zero, invalid, overflow, underflow};
                if (busy) o.busy_err = 1'b1;
                if (poke_done) begin
                    start = 1'b1;
                    a     = 32'h4000_0000;
                    b     = 32'h3F80_0000;
                end
                @(negedge clk);
                start        = 1'b0;
                o.done_after = done;
                o.busy_after = busy;
                return;
            end
            if (!busy) o.busy_err = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        a     = 32'd0;
        b     = 32'd0;
        #1;
        n_checks++;
        if ({busy, done, div_by_zero, invalid, overflow, underflow} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: busy/done/flags=%b required 000000",
                     {busy, done, div_by_zero, invalid, overflow, underflow});
        end
        n_checks++;
        if (result !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_result: got %h required 00000000", result);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_vector(input string name, input logic [31:0] ai, input logic [31:0] bi);
        obs_t    o;
        expect_t e;
        int      want_lat;
        e        = model(ai, bi);
        want_lat = e.special ? 2 : 28;
        run_op(ai, bi, 0, 0, 1'b0, o);
        n_checks++;
        if (o.res !== e.res) begin
            n_fail++;
            $display("FAIL %s_result: a=%h b=%h got %h required %h", name, ai, bi, o.res, e.res);
        end
        n_checks++;
        if (o.flags !== e.flags) begin
            n_fail++;
            $display("FAIL %s_flags: a=%h b=%h got %b required %b", name, ai, bi, o.flags, e.flags);
        end
        n_checks++;
        if (o.lat !== want_lat) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d required %0d", name, o.lat, want_lat);
        end
        n_checks++;
        if ({o.busy_err, o.done_after} !== 2'b00) begin
            n_fail++;
            $display("FAIL %s_handshake: busy_err=%b done_after=%b required 0 0",
                     name, o.busy_err, o.done_after);
        end
    endtask

    task automatic test_directed();
        logic [31:0] va [10];
        logic [31:0] vb [10];
        logic [31:0] req [10];
        va[0] = 32'h40C0_0000; vb[0] = 32'h4000_0000; req[0] = 32'h4040_0000;
        va[1] = 32'h3F80_0000; vb[1] = 32'h4040_0000; req[1] = 32'h3EAA_AAAA;
        va[2] = 32'hBFC0_0000; vb[2] = 32'h3F00_0000; req[2] = 32'hC040_0000;
        va[3] = 32'h3F80_0000; vb[3] = 32'h0000_0000; req[3] = 32'h7F80_0000;
        va[4] = 32'h0000_0000; vb[4] = 32'h0000_0000; req[4] = 32'h7FC0_0000;
        va[5] = 32'h7F00_0000; vb[5] = 32'h3E80_0000; req[5] = 32'h7F80_0000;
        va[6] = 32'h0080_0000; vb[6] = 32'h7F00_0000; req[6] = 32'h0000_0000;
        va[7] = 32'hFF80_0000; vb[7] = 32'h4000_0000; req[7] = 32'h7F80_0000 | 32'h8000_0000;
        va[8] = 32'h4000_0000; vb[8] = 32'hFF80_0000; req[8] = 32'h8000_0000;
        va[9] = 32'h7FC0_0001; vb[9] = 32'h3F80_0000; req[9] = 32'h7FC0_0000;
        for (int i = 0; i < 10; i++) begin
            // Sanity-check the model itself against hand-derived values.
            n_checks++;
            if (model(va[i], vb[i]).res !== req[i]) begin
                n_fail++;
                $display("FAIL model_vec%0d: got %h required %h", i, model(va[i], vb[i]).res, req[i]);
            end
            test_vector($sformatf("vec%0d", i), va[i], vb[i]);
        end
    endtask

    task automatic test_random();
        logic [31:0] ra, rb;
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 9))
                0: ra[30:23] = 8'd0;
                1: rb[30:23] = 8'd0;
                2: ra[30:23] = 8'hFF;
                3: begin rb[30:23] = 8'hFF; rb[22:0] = 23'd0; end
                4: begin ra[30:23] = 8'(200 + $urandom_range(0, 54)); rb[30:23] = 8'(1 + $urandom_range(0, 60)); end
                5: begin ra[30:23] = 8'(1 + $urandom_range(0, 60)); rb[30:23] = 8'(200 + $urandom_range(0, 54)); end
                default: begin
                    ra[30:23] = 8'(96 + $urandom_range(0, 64));
                    rb[30:23] = 8'(96 + $urandom_range(0, 64));
                end
            endcase
            test_vector($sformatf("rand%0d", i), ra, rb);
        end
    endtask

    task automatic test_ignored_start();
        obs_t    o;
        expect_t e;
        e = model(32'h40C0_0000, 32'h4000_0000);
        run_op(32'h40C0_0000, 32'h4000_0000, 10, 0, 1'b1, o);
        n_checks++;
        if (o.res !== e.res || o.lat !== 28) begin
            n_fail++;
            $display("FAIL ignored_start: result %h lat %0d required %h lat 28", o.res, o.lat, e.res);
        end
        n_checks++;
        if (o.busy_after !== 1'b0) begin
            n_fail++;
            $display("FAIL start_in_done: busy after DONE cycle %b required 0", o.busy_after);
        end
        n_checks++;
        if (result !== e.res) begin
            n_fail++;
            $display("FAIL result_held: got %h required %h", result, e.res);
        end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        run_op(32'h3F80_0000, 32'h4040_0000, 0, 15, 1'b0, o);
        n_checks++;
        if ({o.rst_busy, o.rst_done} !== 2'b00 || o.rst_res !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid: busy=%b done=%b result=%h required 0 0 00000000",
                     o.rst_busy, o.rst_done, o.rst_res);
        end
        test_vector("after_reset", 32'hBFC0_0000, 32'h3F00_0000);
    endtask

    task automatic test_back_to_back();
        // Each run_op returns in the first IDLE cycle and the next one starts
        // immediately; mix normal and special-case latencies.
        test_vector("b2b0", 32'h3F80_0000, 32'h0000_0000);
        test_vector("b2b1", 32'h40C0_0000, 32'h4000_0000);
        test_vector("b2b2", 32'h7F00_0000, 32'h3E80_0000);
        test_vector("b2b3", 32'h0000_0000, 32'hC000_0000);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
